imem_load_ctrl: RTL and testbench

IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

---
 rtl/imem_load_ctrl_if.sv | 34 +++
 rtl/imem_load_ctrl.sv | 145 ++++++++++++++
 tb/tb_imem_load_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_load_ctrl_if.sv
// Program-load bus between a host/byte source, the load controller and the
// instruction memory / CPU fetch path.
//   master : host side (drives load requests, bytes, fetch address)
//   slave  : imem_load_ctrl (drives byte_ready, memory ports, stall, status)
interface imem_load_ctrl_if #(
  parameter int unsigned AW = 8
);
  logic          load_start;
  logic [AW-1:0] load_len;
  logic          load_abort;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic [AW-1:0] fetch_addr;
  logic [AW-1:0] mem_raddr;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic          cpu_stall;
  logic          load_done;
  logic          load_err;

  modport master (
    output load_start, load_len, load_abort, byte_valid, byte_data, fetch_addr,
    input  byte_ready, mem_raddr, mem_we, mem_waddr, mem_wdata, cpu_stall,
           load_done, load_err
  );

  modport slave (
    input  load_start, load_len, load_abort, byte_valid, byte_data, fetch_addr,
    output byte_ready, mem_raddr, mem_we, mem_waddr, mem_wdata, cpu_stall,
           load_done, load_err
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Instruction-memory program loader. Collects a byte stream (little-endian
// within each 32-bit word), writes one word per WRITE cycle and stalls the CPU
// while it owns the memory.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : imem_load_ctrl_if.slave (load control, byte stream, memory
//                write/read address, cpu_stall, load_done, load_err)
module imem_load_ctrl #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  imem_load_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW:0] DEPTH_EXT = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic [AW-1:0] word_cnt_q, word_cnt_d;
  logic [AW-1:0] len_q, len_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [31:0]   word_q, word_d;
  logic          err_q, err_d;
  // Zero-length load completes from IDLE without stalling the CPU
  logic          zdone_q, zdone_d;

  logic len_zero;
  logic len_over;

  assign len_zero = (bus.load_len == '0);
  assign len_over = ({1'b0, bus.load_len} > DEPTH_EXT);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      word_cnt_q <= '0;
      len_q      <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      err_q      <= 1'b0;
      zdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      err_q      <= err_d;
      zdone_q    <= zdone_d;
    end
  end

  // Next-state, datapath update and output decode
  always_comb begin
    state_d        = state_q;
    word_cnt_d     = word_cnt_q;
    len_d          = len_q;
    byte_cnt_d     = byte_cnt_q;
    word_d         = word_q;
    err_d          = err_q;
    zdone_d        = 1'b0;
    bus.byte_ready = 1'b0;
    bus.mem_we     = 1'b0;
    bus.load_done  = 1'b0;
    bus.cpu_stall  = 1'b1;

    case (state_q)
      S_IDLE: begin
        bus.cpu_stall = 1'b0;
        bus.load_done = zdone_q;
        if (bus.load_start) begin
          if (len_zero) begin
            zdone_d = 1'b1;
          end else if (len_over) begin
            err_d = 1'b1;
          end else begin
            state_d    = S_RECV;
            word_cnt_d = '0;
            byte_cnt_d = '0;
            err_d      = 1'b0;
            len_d      = bus.load_len;
          end
        end
      end

      S_RECV: begin
        bus.byte_ready = 1'b1;
        if (bus.load_abort) begin
          // Abort beats a same-cycle handshake; the partial word is dropped
          state_d    = S_IDLE;
          err_d      = 1'b1;
          byte_cnt_d = '0;
          word_d     = '0;
        end else if (bus.byte_valid) begin
          word_d[{byte_cnt_q, 3'b000} +: 8] = bus.byte_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        if (bus.load_abort) begin
          state_d    = S_IDLE;
          err_d      = 1'b1;
          byte_cnt_d = '0;
          word_d     = '0;
        end else begin
          bus.mem_we = 1'b1;
          if (word_cnt_q == len_q - AW'(1)) begin
            state_d = S_DONE;
          end else begin
            word_cnt_d = word_cnt_q + AW'(1);
            state_d    = S_RECV;
          end
        end
      end

      S_DONE: begin
        bus.load_done = 1'b1;
        state_d       = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Memory read port follows the CPU only while the loader is idle
  assign bus.mem_raddr = (state_q == S_IDLE) ? bus.fetch_addr : word_cnt_q;
  assign bus.mem_waddr = word_cnt_q;
  assign bus.mem_wdata = word_q;
  assign bus.load_err  = err_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed testbench for imem_load_ctrl with a write scoreboard.
module tb_imem_load_ctrl;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;

  imem_load_ctrl_if #(.AW(8)) bus ();

  imem_load_ctrl #(.DEPTH(64), .AW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  wr_t        exp_q[$];
  logic [7:0] byte_q[$];

  int n_checks = 0;
  int n_err    = 0;
  int n_we, n_done, n_stall, cyc_n, last_we_cyc, last_done_cyc, last_waddr;
  logic last_hs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, expv);
    end
  endtask

  task automatic clr_counts();
    n_we = 0; n_done = 0; n_stall = 0;
  endtask

  // One clock: sample at negedge, scoreboard any write, return at posedge+1
  task automatic cyc();
    wr_t w;
    @(negedge clk);
    cyc_n++;
    last_hs = bus.byte_valid && bus.byte_ready;
    if (bus.cpu_stall) n_stall++;
    if (bus.load_done) begin
      n_done++;
      last_done_cyc = cyc_n;
    end
    if (bus.mem_we) begin
      n_we++;
      last_we_cyc = cyc_n;
      last_waddr  = int'(bus.mem_waddr);
      chk("byte_ready_in_write", 32'(bus.byte_ready), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write_addr", 32'(bus.mem_waddr), 32'hFFFF_FFFF);
      end else begin
        w = exp_q.pop_front();
        chk("waddr", 32'(bus.mem_waddr), 32'(w.addr));
        chk("wdata", bus.mem_wdata, w.data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] addr, input logic [31:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    exp_q.push_back(w);
    for (int b = 0; b < 4; b++) byte_q.push_back(data[8*b +: 8]);
  endtask

  task automatic start_load(input logic [7:0] len);
    bus.load_len   = len;
    bus.load_start = 1'b1;
    cyc();
    bus.load_start = 1'b0;
  endtask

  // Offer queued bytes, optionally with random idle gaps, until all consumed
  task automatic feed(input int gap_max);
    int budget = 3000;
    while (byte_q.size() > 0 && budget > 0) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          bus.byte_valid = 1'b0;
          cyc();
          budget--;
        end
      end
      bus.byte_valid = 1'b1;
      bus.byte_data  = byte_q[0];
      cyc();
      budget--;
      if (last_hs) void'(byte_q.pop_front());
    end
    bus.byte_valid = 1'b0;
    chk("feed_complete", 32'(byte_q.size()), 32'd0);
    byte_q.delete();
  endtask

  task automatic wait_done(input int budget);
    int start = n_done;
    int b = budget;
    while (n_done == start && b > 0) begin
      cyc();
      b--;
    end
    chk("load_done_seen", 32'(n_done - start), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_we"},     32'(bus.mem_we),     32'd0);
    chk({tag, "_load_done"},  32'(bus.load_done),  32'd0);
    chk({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
    chk({tag, "_cpu_stall"},  32'(bus.cpu_stall),  32'd0);
    chk({tag, "_mem_waddr"},  32'(bus.mem_waddr),  32'd0);
    chk({tag, "_mem_wdata"},  bus.mem_wdata,       32'd0);
    chk({tag, "_load_err"},   32'(bus.load_err),   32'd0);
    chk({tag, "_mem_raddr"},  32'(bus.mem_raddr),  32'(bus.fetch_addr));
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.load_start = 1'b0;
    bus.load_len   = '0;
    bus.load_abort = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    bus.fetch_addr = 8'h2A;
    cyc_n = 0; last_we_cyc = 0; last_done_cyc = 0; last_waddr = 0; last_hs = 1'b0;
    clr_counts();

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two-word load, continuous bytes
    clr_counts();
    push_word(8'd0, 32'h00C0_0F13);
    push_word(8'd1, 32'h0240_0F93);
    start_load(8'd2);
    chk("t1_stall_after_start", 32'(bus.cpu_stall), 32'd1);
    feed(0);
    wait_done(20);
    chk("t1_writes", 32'(n_we), 32'd2);
    chk("t1_done_after_last_write", 32'(last_done_cyc - last_we_cyc), 32'd1);
    chk("t1_stall_cycles", 32'(n_stall), 32'd11);
    chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);
    cyc();
    chk("t1_done_one_cycle", 32'(n_done), 32'd1);
    chk("t1_stall_released", 32'(bus.cpu_stall), 32'd0);

    // Same load with random byte gaps
    clr_counts();
    push_word(8'd0, 32'h00C0_0F13);
    push_word(8'd1, 32'h0240_0F93);
    start_load(8'd2);
    feed(3);
    wait_done(20);
    chk("t2_writes", 32'(n_we), 32'd2);
    chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // Full-depth load
    clr_counts();
    bus.fetch_addr = 8'h11;
    for (int i = 0; i < 64; i++)
      push_word(8'(i), {8'(i), 8'(~i), 8'hA5, 8'(i * 3)});
    start_load(8'd64);
    feed(0);
    wait_done(50);
    chk("t3_writes", 32'(n_we), 32'd64);
    chk("t3_last_addr", 32'(last_waddr), 32'd63);
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);
    cyc();
    chk("t3_idle_stall", 32'(bus.cpu_stall), 32'd0);
    chk("t3_raddr_fetch", 32'(bus.mem_raddr), 32'h11);
    bus.fetch_addr = 8'h37;
    #1;
    chk("t3_raddr_follow", 32'(bus.mem_raddr), 32'h37);

    // Zero-length load: done pulse only
    clr_counts();
    start_load(8'd0);
    cyc();
    chk("t4_zero_done", 32'(n_done), 32'd1);
    cyc();
    chk("t4_zero_done_once", 32'(n_done), 32'd1);
    chk("t4_zero_no_write", 32'(n_we), 32'd0);
    chk("t4_zero_no_stall", 32'(n_stall), 32'd0);

    // Over-length load: error, nothing else
    clr_counts();
    start_load(8'd65);
    cyc();
    chk("t4_over_err", 32'(bus.load_err), 32'd1);
    chk("t4_over_no_write", 32'(n_we), 32'd0);
    chk("t4_over_no_stall", 32'(n_stall), 32'd0);
    chk("t4_over_no_done", 32'(n_done), 32'd0);

    // Abort after six bytes of a four-word load, with a same-cycle byte
    clr_counts();
    start_load(8'd4);
    chk("t5_err_cleared", 32'(bus.load_err), 32'd0);
    push_word(8'd0, 32'hDEAD_BEEF);
    byte_q.push_back(8'h55);
    byte_q.push_back(8'h66);
    feed(0);
    bus.load_abort = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h77;
    cyc();
    bus.load_abort = 1'b0;
    bus.byte_valid = 1'b0;
    cyc();
    chk("t5_stall_low", 32'(bus.cpu_stall), 32'd0);
    chk("t5_err_set", 32'(bus.load_err), 32'd1);
    chk("t5_no_done", 32'(n_done), 32'd0);
    chk("t5_one_write", 32'(n_we), 32'd1);
    chk("t5_sb_empty", 32'(exp_q.size()), 32'd0);
    push_word(8'd0, 32'h1234_5678);
    start_load(8'd1);
    chk("t5_restart_err_clear", 32'(bus.load_err), 32'd0);
    feed(0);
    wait_done(20);
    chk("t5_restart_writes", 32'(n_we), 32'd2);

    // Reset in the middle of the second word
    clr_counts();
    push_word(8'd0, 32'h0BAD_CAFE);
    byte_q.push_back(8'hAB);
    byte_q.push_back(8'hCD);
    start_load(8'd2);
    feed(0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clr_counts();
    push_word(8'd0, 32'hCAFE_F00D);
    start_load(8'd1);
    feed(0);
    wait_done(20);
    chk("t6_writes", 32'(n_we), 32'd1);
    chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
